fixed_addsub: RTL and testbench

FIXED_ADDSUB -- requirements
Module: fixed_addsub

---
 rtl/fixed_pkg.sv | 18 +
 rtl/fixed_mag_addsub.sv | 55 +++++
 rtl/fixed_addsub.sv | 116 +++++++++++
 tb/tb_fixed_addsub.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// fixed_pkg: encodings and helper constants shared by the fixed_* blocks.
//   OP_ADD / OP_SUB : op_i encoding (0 = A+B, 1 = A-B)
//   sign_bit(n)     : index of the sign bit in an n-bit sign-magnitude word
//   mag_max(n)      : largest representable magnitude, 2^(n-1)-1 (64-bit wide)
package fixed_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int sign_bit(input int n);
    return n - 1;
  endfunction

  function automatic logic [63:0] mag_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/fixed_mag_addsub.sv
// fixed_mag_addsub: combinational sign-magnitude core for stage 2.
//   eff_i     : effective subtract (signs differ after applying op)
//   a_ge_b_i  : |A| >= |B|, precomputed in stage 1
//   mag_a_i/mag_b_i : operand magnitudes (N-1 bits)
//   sign_a_i  : sign of A;  sign_b_i : sign of B with op folded in
//   result_o  : N-bit sign-magnitude result, never negative zero
//   ovf_o     : magnitude overflow (only on effective add)
module fixed_mag_addsub
  import fixed_pkg::*;
#(
  parameter int N   = 32,
  parameter int SAT = 1
) (
  input  logic         eff_i,
  input  logic         a_ge_b_i,
  input  logic [N-2:0] mag_a_i,
  input  logic [N-2:0] mag_b_i,
  input  logic         sign_a_i,
  input  logic         sign_b_i,
  output logic [N-1:0] result_o,
  output logic         ovf_o
);

  localparam logic [63:0]  MAX_W   = mag_max(N);
  localparam logic [N-2:0] MAG_MAX = MAX_W[N-2:0];

  logic [N-1:0] sum;
  logic [N-2:0] mag;
  logic         sign;
  logic         ovf;

  always_comb begin
    // one extra bit so the carry out of the magnitude is the overflow flag
    sum  = {1'b0, mag_a_i} + {1'b0, mag_b_i};
    mag  = '0;
    sign = 1'b0;
    ovf  = 1'b0;
    if (!eff_i) begin
      ovf  = sum[N-1];
      sign = sign_a_i;
      mag  = (ovf && SAT != 0) ? MAG_MAX : sum[N-2:0];
    end else if (a_ge_b_i) begin
      mag  = mag_a_i - mag_b_i;
      sign = sign_a_i;
    end else begin
      mag  = mag_b_i - mag_a_i;
      sign = sign_b_i;
    end
    // zero (including wrapped zero and -0 operands) is always emitted as +0
    if (mag == '0) sign = 1'b0;
    result_o = {sign, mag};
    ovf_o    = ovf;
  end

endmodule

// File: rtl/fixed_addsub.sv
// fixed_addsub: two-stage pipelined sign-magnitude adder/subtractor with
// valid/ready handshakes on both sides.
//   clk_i, rst_i (async, active-high)
//   valid_i/ready_o : input handshake for opA_i, opB_i, op_i
//   out_valid_o/out_ready_i : output handshake for result_o, ovf_o
// Stage 1 registers operand decode (effective op, compare, magnitudes);
// stage 2 registers the arithmetic result from fixed_mag_addsub.
module fixed_addsub
  import fixed_pkg::*;
#(
  parameter int N   = 32,
  parameter int Q   = 15,
  parameter int SAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         op_i,
  input  logic [N-1:0] opA_i,
  input  logic [N-1:0] opB_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] result_o,
  output logic         ovf_o
);

  localparam int SB = sign_bit(N);

  // Q only tags the format; arithmetic is format-agnostic
  if (Q < 0 || Q > N - 2) begin : g_bad_q
    $error("fixed_addsub: Q out of range 0..N-2");
  end

  typedef struct packed {
    logic         eff;
    logic         a_ge_b;
    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;
    logic         sign_a;
    logic         sign_b;   // sign of B with op folded in
  } s1_t;

  logic [2:1]   vld_pipe_q, vld_pipe_d;
  s1_t          s1_q, s1_d;
  logic [N-1:0] res_q, res_d;
  logic         ovf_q, ovf_d;

  logic         adv2, adv1, in_xfer;
  logic [N-1:0] s2_res;
  logic         s2_ovf;
  logic         sgn_b_eff;

  assign adv2    = !vld_pipe_q[2] | out_ready_i;
  assign adv1    = !vld_pipe_q[1] | adv2;
  assign ready_o = adv1 & !rst_i;
  assign in_xfer = valid_i & ready_o;

  assign sgn_b_eff = opB_i[SB] ^ (op_i == OP_SUB);

  fixed_mag_addsub #(.N(N), .SAT(SAT)) u_mag (
    .eff_i    (s1_q.eff),
    .a_ge_b_i (s1_q.a_ge_b),
    .mag_a_i  (s1_q.mag_a),
    .mag_b_i  (s1_q.mag_b),
    .sign_a_i (s1_q.sign_a),
    .sign_b_i (s1_q.sign_b),
    .result_o (s2_res),
    .ovf_o    (s2_ovf)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    // result/ovf only change on a real stage-2 load, so they hold while stalled
    if (adv2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        res_d = s2_res;
        ovf_d = s2_ovf;
      end
    end
    if (adv1) begin
      vld_pipe_d[1] = in_xfer;
      if (in_xfer) begin
        s1_d.sign_a = opA_i[SB];
        s1_d.sign_b = sgn_b_eff;
        s1_d.eff    = opA_i[SB] ^ sgn_b_eff;
        s1_d.mag_a  = opA_i[N-2:0];
        s1_d.mag_b  = opB_i[N-2:0];
        s1_d.a_ge_b = opA_i[N-2:0] >= opB_i[N-2:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid_o = vld_pipe_q[2];
  assign result_o    = res_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fixed_addsub.sv
// tb_fixed_addsub: directed and random checks of fixed_addsub (N=32, Q=15).
// Two instances share the inputs: dut saturates, dut_w wraps.
module tb_fixed_addsub;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        valid_i = 1'b0, op_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] opA_i = '0, opB_i = '0;
  logic        ready_o, out_valid_o, ovf_o;
  logic [31:0] result_o;
  logic        ready_w, out_valid_w, ovf_w;
  logic [31:0] result_w;

  int checks = 0, errors = 0;
  logic [32:0] q_s[$], q_w[$];
  int sent = 0, rcvd = 0;

  fixed_addsub #(.N(32), .Q(15), .SAT(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .opA_i(opA_i), .opB_i(opB_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .result_o(result_o), .ovf_o(ovf_o));

  fixed_addsub #(.N(32), .Q(15), .SAT(0)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_w),
    .op_i(op_i), .opA_i(opA_i), .opB_i(opB_i), .out_valid_o(out_valid_w),
    .out_ready_i(out_ready_i), .result_o(result_w), .ovf_o(ovf_w));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // reference: signed integer arithmetic on decoded operands
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic op, input bit sat);
    longint va, vb, r, m;
    logic   ov, sg;
    va = longint'(a[30:0]);
    if (a[31]) va = -va;
    vb = longint'(b[30:0]);
    if (b[31]) vb = -vb;
    r  = op ? va - vb : va + vb;
    m  = (r < 0) ? -r : r;
    ov = m > 64'sd2147483647;
    if (ov) m = sat ? 64'sd2147483647 : m % 64'sd2147483648;
    sg = (r < 0) && (m != 0);
    return {ov, sg, m[30:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:0] = 31'($urandom_range(0, 3));
      1: v[30:0] = 31'h7FFFFFFF - 31'($urandom_range(0, 3));
      2: v[30:0] = '0;
      default: ;
    endcase
    return v;
  endfunction

  // single op with out_ready_i high: out_valid_o must appear on the 2nd edge
  task automatic send1(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] er, input logic eo,
                       input logic [31:0] erw, input logic eow);
    opA_i = a; opB_i = b; op_i = op; valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk1({tag, ".rdy"}, ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    chk1({tag, ".lat1"}, out_valid_o, 1'b0);
    tick();
    chk1({tag, ".lat2"}, out_valid_o, 1'b1);
    chk({tag, ".res"}, result_o, er);
    chk1({tag, ".ovf"}, ovf_o, eo);
    chk({tag, ".res_w"}, result_w, erw);
    chk1({tag, ".ovf_w"}, ovf_w, eow);
    tick();
    chk1({tag, ".drain"}, out_valid_o, 1'b0);
  endtask

  initial begin
    logic [32:0] e;

    // reset state
    tick(); tick();
    chk1("rst.rdy", ready_o, 1'b0);
    chk1("rst.vld", out_valid_o, 1'b0);
    chk("rst.res", result_o, 32'h0);
    chk1("rst.ovf", ovf_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk1("rel.rdy", ready_o, 1'b1);

    // directed single operations
    send1("sub_pos",  32'h00018000, 32'h00008000, 1'b1, 32'h00010000, 1'b0, 32'h00010000, 1'b0);
    send1("sub_neg",  32'h00008000, 32'h00018000, 1'b1, 32'h80010000, 1'b0, 32'h80010000, 1'b0);
    send1("add_zero", 32'h00008000, 32'h80008000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    send1("ovf_max",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1);
    send1("add_negs", 32'h80008000, 32'h80010000, 1'b0, 32'h80018000, 1'b0, 32'h80018000, 1'b0);
    send1("negzero",  32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    send1("ovf_neg",  32'hFFFFFFFF, 32'h80000002, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h80000001, 1'b1);
    send1("nz_plus5", 32'h80000000, 32'h00000005, 1'b0, 32'h00000005, 1'b0, 32'h00000005, 1'b0);
    send1("sub_nega", 32'h00008000, 32'h80008000, 1'b1, 32'h00010000, 1'b0, 32'h00010000, 1'b0);

    // back-to-back with downstream stalled
    out_ready_i = 1'b0; valid_i = 1'b1;
    opA_i = 32'h00008000; opB_i = 32'h00008000; op_i = 1'b0;
    tick();
    chk1("bp.rdy1", ready_o, 1'b1);
    chk1("bp.vld1", out_valid_o, 1'b0);
    opA_i = 32'h00008000; opB_i = 32'h00018000; op_i = 1'b1;
    tick();
    chk1("bp.vld2", out_valid_o, 1'b1);
    chk("bp.res2", result_o, 32'h00010000);
    chk1("bp.rdy2", ready_o, 1'b0);
    opA_i = 32'h00000003; opB_i = 32'h00000004; op_i = 1'b0;
    tick();
    chk1("bp.rdy3", ready_o, 1'b0);
    chk1("bp.vld3", out_valid_o, 1'b1);
    chk("bp.hold", result_o, 32'h00010000);
    out_ready_i = 1'b1;
    #1;
    chk1("bp.rdy4", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    chk1("bp.vld5", out_valid_o, 1'b1);
    chk("bp.r2", result_o, 32'h80010000);
    tick();
    chk1("bp.vld6", out_valid_o, 1'b1);
    chk("bp.r3", result_o, 32'h00000007);
    tick();
    chk1("bp.empty", out_valid_o, 1'b0);

    // reset with two ops in flight
    out_ready_i = 1'b0; valid_i = 1'b1;
    opA_i = 32'h7FFFFFFF; opB_i = 32'h00000001; op_i = 1'b0;
    tick();
    opA_i = 32'h00008000; opB_i = 32'h00008000; op_i = 1'b0;
    tick();
    valid_i = 1'b0;
    chk1("rp.vld", out_valid_o, 1'b1);
    chk1("rp.ovf", ovf_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    chk1("rp.vld0", out_valid_o, 1'b0);
    chk("rp.res0", result_o, 32'h0);
    chk1("rp.ovf0", ovf_o, 1'b0);
    chk1("rp.rdy0", ready_o, 1'b0);
    chk("rp.res0_w", result_w, 32'h0);
    tick();
    rst_i = 1'b0; out_ready_i = 1'b1;
    tick();
    chk1("rp.stale1", out_valid_o, 1'b0);
    tick();
    chk1("rp.stale2", out_valid_o, 1'b0);
    send1("rp.next", 32'h00018000, 32'h00008000, 1'b1, 32'h00010000, 1'b0, 32'h00010000, 1'b0);

    // random stream with random backpressure
    for (int i = 0; i < 400; i++) begin
      valid_i     = $urandom_range(0, 3) != 0;
      opA_i       = rnd_op();
      opB_i       = rnd_op();
      op_i        = 1'($urandom_range(0, 1));
      out_ready_i = $urandom_range(0, 2) != 0;
      #1;
      if (out_valid_o && out_ready_i) begin
        checks++;
        assert (q_s.size() > 0) else begin
          errors++;
          $error("FAIL rnd.extra obs=result %h with empty queue exp=no result", result_o);
        end
        if (q_s.size() > 0) begin
          rcvd++;
          e = q_s.pop_front();
          chk("rnd.res", result_o, e[31:0]);
          chk1("rnd.ovf", ovf_o, e[32]);
          e = q_w.pop_front();
          chk1("rnd.vld_w", out_valid_w, 1'b1);
          chk("rnd.res_w", result_w, e[31:0]);
          chk1("rnd.ovf_w", ovf_w, e[32]);
        end
      end
      if (valid_i && ready_o) begin
        sent++;
        q_s.push_back(model(opA_i, opB_i, op_i, 1'b1));
        q_w.push_back(model(opA_i, opB_i, op_i, 1'b0));
      end
      tick();
    end
    valid_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid_o && q_s.size() > 0) begin
        rcvd++;
        e = q_s.pop_front();
        chk("drn.res", result_o, e[31:0]);
        chk1("drn.ovf", ovf_o, e[32]);
        e = q_w.pop_front();
        chk("drn.res_w", result_w, e[31:0]);
        chk1("drn.ovf_w", ovf_w, e[32]);
      end
      tick();
    end
    chk("rnd.lost", 32'(q_s.size()), 32'd0);
    chk("rnd.count", 32'(rcvd), 32'(sent));
    chk1("rnd.idle", out_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
